score_scheduler: RTL
====================

# score_scheduler

Arbitrates scoring events from the game logic and turns them into the single-cycle `scorewire` pulses consumed by the score display. There are three requesters: line clears, hard drops and soft-drop ticks. The block also owns the cleared-line count and the level, and applies the level multiplier to line-clear points. It sits between the playfield/piece controller and the score display, all in the `clk_25_175` pixel-clock domain.

## Interface
Parameters:
- `LEVEL_MAX`, default 15: saturation value of `level`; must be ≤ 15.
- `LINES_PER_LEVEL`, default 10: lines per level step; must be in 4..63.

Ports:
- `clk_25_175`  in  1  pixel clock; the only clock.
- `reset`  in  1  asynchronous, active-low reset.
- `clear_req`  in  1  line-clear request; held high until acked.
- `clear_count`  in  3  lines cleared; 1..4 valid.
- `clear_ack`  out  1  one-cycle grant pulse.
- `hdrop_req`  in  1  hard-drop request; held high until acked.
- `hdrop_rows`  in  5  rows fallen, 0..31.
- `hdrop_ack`  out  1  one-cycle grant pulse.
- `sdrop_req`  in  1  soft-drop tick request; held high until acked.
- `sdrop_ack`  out  1  one-cycle grant pulse.
- `game_over`  in  1  level-sensitive; while high, no new grants are issued.
- `new_game`  in  1  synchronous clear of game state.
- `scorewire`  out  16  points to add; nonzero for at most one cycle per event.
- `level`  out  4  current level.
- `lines`  out  10  total lines cleared, saturating at 999.
- `busy`  out  1  high when the state is not IDLE.

## Operation
- States are IDLE and MULT.
- Grant in IDLE:
  - A grant needs `game_over`=0 and `new_game`=0.
  - Fixed priority: clear > hdrop > sdrop.
  - The winner's inputs are sampled on the grant edge.
  - The winner's ack is registered high for exactly the next cycle. The state goes to MULT.
- Point base and repeat count:
  - Clear: base = 40 / 100 / 300 / 1000 for count 1 / 2 / 3 / 4; repeat count `cnt` = `level`.
  - Hard drop: base = 2×`hdrop_rows`; `cnt` = 0.
  - Soft drop: base = 1; `cnt` = 0.
- `clear_count` of 0 or 5..7 is still acked, but gives base 0 and adds no lines.
- MULT:
  - Each edge does `acc` += base.
  - If `cnt` = 0, the final sum is loaded into `scorewire` and the state returns to IDLE. Otherwise `cnt` decrements.
  - Result is base×(level+1); `acc` resets to 0 on grant.
  - Max is 1000×16 = 16000, so 16 bits never overflow.
- The level used as multiplier is the level at the grant edge, before this clear's lines are added.
- Line accounting, on the same edge that loads `scorewire` for a valid clear:
  - `lines` += count, saturating at 999.
  - `lines_in_level` += count. If it reaches ≥ `LINES_PER_LEVEL`, subtract `LINES_PER_LEVEL` and increment `level`, saturating at `LEVEL_MAX`.
  - At most one level step per clear.
- `scorewire` is 0 in every cycle except the emit cycle. A hard drop of 0 rows emits 0.
- `new_game`:
  - Has the highest priority and forces IDLE.
  - Clears `acc`, `cnt`, `level`, `lines`, `lines_in_level`, `scorewire` and all acks on that edge.
  - Any in-flight event is discarded and not emitted.
- `game_over` rising while in MULT: the in-flight event completes and is emitted. No further grants.

## Timing
- Reset (async assert) sets all outputs to 0 and the state to IDLE.
- Grant edge E0; ack is high during E0→E1.
- Drops: `scorewire` is valid during E1→E2.
- Clears: `scorewire` is valid during E(level+1)→E(level+2).
- `lines`/`level` change on the same edge that loads `scorewire`.
- `busy` is high from E0 to the emit edge. The earliest next grant is at the emit edge +1.
- A requester drops its req on the edge after seeing ack. No double grant is possible, because MULT lasts ≥ 1 edge.
- Simultaneous requests: the losers keep waiting and are served in priority order on later IDLE edges.

## Test plan
- Level 0, `clear_req` with count 4 → `clear_ack` one cycle after E0; `scorewire`=1000 for exactly one cycle at E1; `lines`=4, `level`=0.
- Preload level 2 (20 lines via clears), then clear count 2 → `scorewire`=300 at E3; `busy` high for 3 cycles; `lines`=22.
- Same cycle `clear_req`(count 1) + `hdrop_req`(rows 7) + `sdrop_req` at level 0 → emits 40, then 14, then 1, in that order; each ack fires once; no overlap.
- Clears of count 4, 4, 3 from reset → `level` goes 0 → 0 → 1 on the third emit; `lines`=11; then 150 further cleared lines → `level` saturates at 15 and `lines` continues counting.
- Assert `reset` low mid-MULT of a level-5 clear → `scorewire` never pulses; all outputs 0; after release a fresh sdrop emits 1 at E1.
- `game_over` high with `sdrop_req` held → no ack for 100 cycles; assert `new_game` → `level`/`lines` = 0; drop `game_over` → grant proceeds.

Source files
------------

// File: rtl/score_scheduler_if.sv
// score_scheduler_if: request/grant handshakes and score/level outputs between game logic and score_scheduler.
interface score_scheduler_if;
    logic        clear_req;
    logic [2:0]  clear_count;
    logic        clear_ack;
    logic        hdrop_req;
    logic [4:0]  hdrop_rows;
    logic        hdrop_ack;
    logic        sdrop_req;
    logic        sdrop_ack;
    logic        game_over;
    logic        new_game;
    logic [15:0] scorewire;
    logic [3:0]  level;
    logic [9:0]  lines;
    logic        busy;
    modport master (
        output clear_req, clear_count, hdrop_req, hdrop_rows, sdrop_req, game_over, new_game,
        input  clear_ack, hdrop_ack, sdrop_ack, scorewire, level, lines, busy
    );
    modport slave (
        input  clear_req, clear_count, hdrop_req, hdrop_rows, sdrop_req, game_over, new_game,
        output clear_ack, hdrop_ack, sdrop_ack, scorewire, level, lines, busy
    );
endinterface

// File: rtl/score_scheduler.sv
// score_scheduler: priority arbiter for scoring events; multiplies clear points by level+1
// through repeated addition and tracks lines and level.
module score_scheduler #(
    parameter int LEVEL_MAX       = 15,
    parameter int LINES_PER_LEVEL = 10
) (
    input logic               clk_25_175,
    input logic               reset,
    score_scheduler_if.slave  bus
);
    typedef enum logic {IDLE, MULT} state_t;
    localparam logic [6:0] LPL     = 7'(LINES_PER_LEVEL);
    localparam logic [3:0] LVL_MAX = 4'(LEVEL_MAX);
    state_t      state;
    logic [9:0]  base;
    logic [3:0]  cnt;
    logic [15:0] acc;
    logic [2:0]  add;
    logic [6:0]  lil;
    logic [9:0]  clear_base;
    logic        clear_ok;
    logic        grant;
    logic [15:0] total;
    logic [10:0] lines_sum;
    logic [6:0]  lil_sum;
    always_comb begin
        clear_ok   = bus.clear_count inside {[3'd1:3'd4]};
        clear_base = bus.clear_count == 3'd1 ? 10'd40  :
                     bus.clear_count == 3'd2 ? 10'd100 :
                     bus.clear_count == 3'd3 ? 10'd300 :
                     bus.clear_count == 3'd4 ? 10'd1000 : 10'd0;
        grant      = state == IDLE && !bus.game_over && !bus.new_game &&
                     (bus.clear_req || bus.hdrop_req || bus.sdrop_req);
        total      = acc + 16'(base);
        lines_sum  = {1'b0, bus.lines} + {8'b0, add};
        lil_sum    = lil + {4'b0, add};
    end
    assign bus.busy = state == MULT;
    always_ff @(posedge clk_25_175 or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            base          <= '0;
            cnt           <= '0;
            acc           <= '0;
            add           <= '0;
            lil           <= '0;
            bus.clear_ack <= 1'b0;
            bus.hdrop_ack <= 1'b0;
            bus.sdrop_ack <= 1'b0;
            bus.scorewire <= '0;
            bus.level     <= '0;
            bus.lines     <= '0;
        end else if (bus.new_game) begin
            state         <= IDLE;
            base          <= '0;
            cnt           <= '0;
            acc           <= '0;
            add           <= '0;
            lil           <= '0;
            bus.clear_ack <= 1'b0;
            bus.hdrop_ack <= 1'b0;
            bus.sdrop_ack <= 1'b0;
            bus.scorewire <= '0;
            bus.level     <= '0;
            bus.lines     <= '0;
        end else begin
            bus.clear_ack <= 1'b0;
            bus.hdrop_ack <= 1'b0;
            bus.sdrop_ack <= 1'b0;
            bus.scorewire <= '0;
            if (state == IDLE) begin
                if (grant) begin
                    state <= MULT;
                    acc   <= '0;
                    if (bus.clear_req) begin
                        bus.clear_ack <= 1'b1;
                        base          <= clear_base;
                        cnt           <= bus.level;
                        add           <= clear_ok ? bus.clear_count : 3'd0;
                    end else if (bus.hdrop_req) begin
                        bus.hdrop_ack <= 1'b1;
                        base          <= {4'b0, bus.hdrop_rows, 1'b0};
                        cnt           <= '0;
                        add           <= '0;
                    end else begin
                        bus.sdrop_ack <= 1'b1;
                        base          <= 10'd1;
                        cnt           <= '0;
                        add           <= '0;
                    end
                end
            end else begin
                acc <= total;
                if (cnt == 4'd0) begin
                    // drops carry add=0, so line accounting is a no-op for them
                    state         <= IDLE;
                    bus.scorewire <= total;
                    bus.lines     <= lines_sum > 11'd999 ? 10'd999 : lines_sum[9:0];
                    if (lil_sum >= LPL) begin
                        lil <= lil_sum - LPL;
                        if (bus.level < LVL_MAX) bus.level <= bus.level + 4'd1;
                    end else begin
                        lil <= lil_sum;
                    end
                end else begin
                    cnt <= cnt - 4'd1;
                end
            end
        end
    end
endmodule
